// File: rtl/reg_file_2r1w_pkg.sv
// Shared widths and constants for the RV32I integer register file and the
// decode / write-back stages that address it.
package reg_file_2r1w_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       reg_data_t;

  // x0 is hardwired to zero
  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/reg_file_2r1w_read_port.sv
// One combinational read port: x0 masking, write-to-read bypass, array select.
module regfile_read_port
  import reg_file_2r1w_pkg::*;
#(
  parameter int XLEN_P  = XLEN,
  parameter int NREGS_P = NREGS,
  parameter bit BYPASS  = 1'b1
) (
  input  logic [NREGS_P-1:0][XLEN_P-1:0] regs_i,
  input  logic [REG_ADDR_W-1:0]          rd_addr_i,
  input  logic                           wr_en_i,
  input  logic [REG_ADDR_W-1:0]          wr_addr_i,
  input  logic [XLEN_P-1:0]              wr_data_i,
  output logic [XLEN_P-1:0]              rd_data_o
);

  logic hit;

  // Bypass only when a write to the same non-zero register is in flight
  assign hit = BYPASS && wr_en_i && (wr_addr_i == rd_addr_i);

  // x0 has priority over both bypass and the stored value
  always_comb begin
    rd_data_o = regs_i[rd_addr_i];
    if (hit)
      rd_data_o = wr_data_i;
    if (rd_addr_i == ZERO_REG)
      rd_data_o = '0;
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// RV32I integer register file: 32 x XLEN, two combinational read ports,
// one synchronous write port, x0 hardwired to zero, optional bypass.
module reg_file_2r1w
  import reg_file_2r1w_pkg::*;
#(
  parameter int XLEN_P  = XLEN,
  parameter int NREGS_P = NREGS,
  parameter bit BYPASS  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [XLEN_P-1:0]     wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  input  logic [REG_ADDR_W-1:0] rd_addr2,
  output logic [XLEN_P-1:0]     rd_data1,
  output logic [XLEN_P-1:0]     rd_data2,
  output logic                  wr_ack
);

  logic [NREGS_P-1:0][XLEN_P-1:0] regs_q, regs_d;
  logic                           wr_ack_q, wr_ack_d;
  logic                           wr_acc;

  logic [1:0][REG_ADDR_W-1:0] rd_addr_v;
  logic [1:0][XLEN_P-1:0]     rd_data_v;

  assign wr_acc = wr_en && (wr_addr != ZERO_REG);

  // Next state of the array: only an accepted write changes one entry
  always_comb begin
    regs_d   = regs_q;
    wr_ack_d = wr_acc;
    if (wr_acc)
      regs_d[wr_addr] = wr_data;
  end

  // Storage and ack flag; reset wins over a concurrent write
  always_ff @(posedge clk) begin
    if (!rst) begin
      regs_q   <= '0;
      wr_ack_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      wr_ack_q <= wr_ack_d;
    end
  end

  assign wr_ack = wr_ack_q;

  assign rd_addr_v[0] = rd_addr1;
  assign rd_addr_v[1] = rd_addr2;
  assign rd_data1     = rd_data_v[0];
  assign rd_data2     = rd_data_v[1];

  for (genvar p = 0; p < 2; p++) begin : g_rp
    regfile_read_port #(
      .XLEN_P (XLEN_P),
      .NREGS_P(NREGS_P),
      .BYPASS (BYPASS)
    ) u_rp (
      .regs_i   (regs_q),
      .rd_addr_i(rd_addr_v[p]),
      .wr_en_i  (wr_en),
      .wr_addr_i(wr_addr),
      .wr_data_i(wr_data),
      .rd_data_o(rd_data_v[p])
    );
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench: a bypass and a no-bypass register file share stimulus;
// a reference model predicts each cycle's outputs, a monitor compares.
module tb_reg_file_2r1w;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0, rd_addr1 = '0, rd_addr2 = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;
  logic        b_ack, n_ack;

  always #5 clk = ~clk;

  reg_file_2r1w #(.BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(b_rd1), .rd_data2(b_rd2), .wr_ack(b_ack)
  );

  reg_file_2r1w #(.BYPASS(1'b0)) u_nob (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(n_rd1), .rd_data2(n_rd2), .wr_ack(n_ack)
  );

  typedef struct {
    logic [31:0] b1, b2, n1, n2;
    logic        ack;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [32];
  logic        ack_m;
  int          checks = 0;
  int          errors = 0;

  // Architectural read rule
  function automatic logic [31:0] rd_model(int a, bit byp, bit we, int wa, logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (byp && we && wa == a) return wd;
    return mem[a];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, predict outputs, then advance the model
  task automatic cyc(bit r, bit we, int wa, logic [31:0] wd, int a1, int a2, bit push = 1'b1);
    exp_t e;
    rst = r; wr_en = we; wr_addr = 5'(wa); wr_data = wd;
    rd_addr1 = 5'(a1); rd_addr2 = 5'(a2);
    if (push) begin
      e.b1  = rd_model(a1, 1'b1, we, wa, wd);
      e.b2  = rd_model(a2, 1'b1, we, wa, wd);
      e.n1  = rd_model(a1, 1'b0, we, wa, wd);
      e.n2  = rd_model(a2, 1'b0, we, wa, wd);
      e.ack = ack_m;
      sb.push_back(e);
    end
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      ack_m = 1'b0;
    end else begin
      ack_m = we && (wa != 0);
      if (we && wa != 0) mem[wa] = wd;
    end
    #1;
  endtask

  // Monitor: outputs are settled by the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("byp_rd1", b_rd1, e.b1);
        chk("byp_rd2", b_rd2, e.b2);
        chk("nob_rd1", n_rd1, e.n1);
        chk("nob_rd2", n_rd2, e.n2);
        chk("byp_ack", {31'b0, b_ack}, {31'b0, e.ack});
        chk("nob_ack", {31'b0, n_ack}, {31'b0, e.ack});
      end
    end
  end

  initial begin
    int wa, a1, a2;
    bit r, we;
    ack_m = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    @(posedge clk); #1;
    cyc(1'b0, 1'b0, 0, 32'h0, 0, 0, 1'b0);      // initial reset, outputs unknown before it

    // reset clears a preloaded register
    cyc(1'b1, 1'b1, 5, 32'hDEADBEEF, 0, 0);
    cyc(1'b0, 1'b0, 0, 32'h0, 5, 5);
    cyc(1'b1, 1'b0, 0, 32'h0, 5, 0);

    // basic write/read and single-cycle ack
    cyc(1'b1, 1'b1, 3, 32'h12345678, 0, 0);
    cyc(1'b1, 1'b0, 0, 32'h0, 0, 3);
    cyc(1'b1, 1'b0, 0, 32'h0, 3, 3);

    // x0 protection, including same-cycle read
    cyc(1'b1, 1'b1, 0, 32'hFFFFFFFF, 0, 0);
    cyc(1'b1, 1'b0, 0, 32'h0, 0, 0);

    // bypass vs. no bypass on both ports
    cyc(1'b1, 1'b1, 7, 32'h1, 0, 0);
    cyc(1'b1, 1'b1, 7, 32'hA5A5A5A5, 7, 7);
    cyc(1'b1, 1'b0, 0, 32'h0, 7, 7);

    // reset colliding with a write, bypass still visible during reset
    cyc(1'b0, 1'b1, 9, 32'h55, 9, 3);
    cyc(1'b1, 1'b0, 0, 32'h0, 9, 3);
    cyc(1'b1, 1'b1, 9, 32'h55, 0, 0);
    cyc(1'b1, 1'b0, 0, 32'h0, 9, 9);

    // randomized traffic, narrow address range to force collisions
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 29) != 0);
      we = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) != 0) begin
        wa = $urandom_range(0, 7); a1 = $urandom_range(0, 7); a2 = $urandom_range(0, 7);
      end else begin
        wa = $urandom_range(0, 31); a1 = $urandom_range(0, 31); a2 = $urandom_range(0, 31);
      end
      cyc(r, we, wa, $urandom, a1, a2);
    end

    cyc(1'b1, 1'b0, 0, 32'h0, 0, 0, 1'b0);
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
